// File: rtl/spi_rram_pkg.sv
// Shared types and constants for the RRAM configuration SPI master.
package spi_rram_pkg;

  localparam int unsigned ADDR_BITS_DEF = 5;
  localparam int unsigned DATA_BITS_DEF = 160;

  // Frame bit positions, counted from the first bit on the wire.
  localparam int unsigned RW_BIT_POS   = 0;
  localparam int unsigned ADDR_BIT_POS = 1;

  // Known register used as a read-back signature.
  localparam logic [4:0]  APB_RST_ADDR = 5'h1F;
  localparam logic [23:0] APB_RST_SIG  = 24'h52414D;

  // Total frame length: R/W bit, address, data.
  function automatic int unsigned frame_len(input int unsigned addr_bits,
                                            input int unsigned data_bits);
    return 1 + addr_bits + data_bits;
  endfunction

  localparam int unsigned NB = frame_len(ADDR_BITS_DEF, DATA_BITS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period tick generator: one tick every CLK_DIV cycles, restartable.
module spi_half_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Reload on restart or expiry, otherwise count down.
  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end
  end

  // Counter and registered tick flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RELOAD;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == '0);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/spi_master_rram.sv
// SPI mode-1 master issuing single register reads/writes to the RRAM config slave.
module spi_master_rram
  import spi_rram_pkg::*;
#(
  parameter int unsigned ADDR_BITS_N = 5,
  parameter int unsigned DATA_BITS_M = 160,
  parameter int unsigned CLK_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_BITS_N-1:0] req_addr,
  input  logic [DATA_BITS_M-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_BITS_M-1:0] rsp_rdata,
  output logic                   busy,
  output logic                   sclk,
  output logic                   sc,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int unsigned FRAME_N    = frame_len(ADDR_BITS_N, DATA_BITS_M);
  localparam int unsigned BIT_W      = $clog2(FRAME_N);
  localparam int unsigned DATA_START = ADDR_BIT_POS + ADDR_BITS_N;

  state_e                 state_q, state_d;
  logic [FRAME_N-1:0]     frame_q, frame_d;
  logic [DATA_BITS_M-1:0] rx_q, rx_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   high_q, high_d;
  logic                   wr_q, wr_d;
  logic                   sclk_q, sclk_d;
  logic                   sc_q, sc_d;
  logic                   mosi_q, mosi_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS_M-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                   accept_c;
  logic                   tick;
  logic [DATA_BITS_M-1:0] wdata_c;

  assign accept_c = (state_q == ST_IDLE) && ready_q && req_valid;
  assign wdata_c  = req_write ? req_wdata : {DATA_BITS_M{1'b0}};

  spi_half_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_half_tick (
    .clk      (clk),
    .rst      (rst),
    .restart_i(accept_c),
    .tick_o   (tick)
  );

  // Next-state and next-output logic; every phase step waits for a tick.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    high_d      = high_q;
    wr_d        = wr_q;
    sclk_d      = sclk_q;
    sc_d        = sc_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_SETUP;
          frame_d = {req_write, req_addr, wdata_c};
          wr_d    = req_write;
          rx_d    = '0;
          bit_d   = '0;
          high_d  = 1'b0;
          sc_d    = 1'b1;
          sclk_d  = 1'b0;
          mosi_d  = req_write;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          high_d  = 1'b1;
          mosi_d  = frame_q[FRAME_N-1];
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (high_q) begin
            // Falling edge: capture miso only inside the data field of a read.
            sclk_d = 1'b0;
            high_d = 1'b0;
            if (!wr_q && (bit_q >= BIT_W'(DATA_START))) begin
              rx_d = {rx_q[DATA_BITS_M-2:0], miso};
            end
          end else if (bit_q == BIT_W'(FRAME_N - 1)) begin
            state_d = ST_HOLD;
            mosi_d  = 1'b0;
          end else begin
            // Rising edge: advance to the next frame bit.
            bit_d   = bit_q + BIT_W'(1);
            frame_d = {frame_q[FRAME_N-2:0], 1'b0};
            mosi_d  = frame_q[FRAME_N-2];
            sclk_d  = 1'b1;
            high_d  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          sc_d    = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : rx_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      high_q      <= 1'b0;
      wr_q        <= 1'b0;
      sclk_q      <= 1'b0;
      sc_q        <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      high_q      <= high_d;
      wr_q        <= wr_d;
      sclk_q      <= sclk_d;
      sc_q        <= sc_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign sclk      = sclk_q;
  assign sc        = sc_q;
  assign mosi      = mosi_q;

endmodule

// File: doc/spi_master_rram.md
Name: spi_master_rram

Overview:
SPI mode-1 master (CPOL=0, CPHA=1) that drives the RRAM configuration SPI slave from an on-chip or test-harness controller. It accepts one register read or write request at a time, serialises it onto sclk/sc/mosi, and captures miso. For reads it returns the register contents on a one-cycle response strobe. It is the initiator counterpart of the slave's register array and is used for on-chip self-test and as the bench driver.

Parameters:
ADDR_BITS_N, 5, register address width; matches CNFG_REG_ADDR_BITS_N.
DATA_BITS_M, 160, register data width; matches PROG_CNFG_BITS_N.
CLK_DIV, 2, clk cycles per sclk half-period; legal values are 1 or more.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
req_write  in  1  1 = register write, 0 = register read
req_addr  in  ADDR_BITS_N  register address
req_wdata  in  DATA_BITS_M  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse at transaction end
rsp_rdata  out  DATA_BITS_M  read data; 0 after a write
busy  out  1  high from acceptance to rsp_valid inclusive
sclk  out  1  SPI clock, idles low
sc  out  1  chip select, active high
mosi  out  1  master out, slave in
miso  in  1  master in, slave out

Behaviour:
- Frame format, MSB first, NB = 1 + ADDR_BITS_N + DATA_BITS_M bits (166 by default):
  - bit 0: R/W (1 = write).
  - next ADDR_BITS_N bits: address.
  - last DATA_BITS_M bits: data. For a write the master drives req_wdata; for a read mosi = 0 and the slave drives miso.
- Outputs on reset: sclk=0, sc=0, mosi=0, req_ready=1 one cycle after rst deasserts, rsp_valid=0, rsp_rdata=0, busy=0.
- All request fields are captured into a shift register in the acceptance cycle. Later changes on req_* have no effect on the transaction in flight.
- Half-period tick: a counter produces a tick every CLK_DIV cycles. It is restarted at acceptance. All FSM phase steps occur on ticks.
- FSM states:
  - IDLE: req_ready=1. On acceptance go to SETUP.
  - SETUP: sc=1, sclk=0, mosi=frame bit 0. Lasts 1 half-period, then SHIFT.
  - SHIFT: 2*NB half-periods. sclk rises at the start of each bit and falls mid-bit. mosi updates in the same cycle sclk rises (the slave samples on the falling edge). miso is sampled into the read shift register in the cycle sclk is driven low. After the NB-th falling edge go to HOLD.
  - HOLD: sclk=0, sc=1 for 1 half-period, then GAP.
  - GAP: sc=0 for 1 half-period, then DONE. GAP guarantees minimum sc deassertion between frames.
  - DONE: 1 cycle. rsp_valid=1 and rsp_rdata = last DATA_BITS_M miso samples (0 if it was a write). Then IDLE.
- Latency: acceptance cycle T to rsp_valid cycle is (2*NB+3)*CLK_DIV+1 cycles. With defaults that is 671 cycles.
- rsp_rdata holds its value until the next rsp_valid or rst.
- A req_valid while busy is ignored (req_ready=0); the request is neither queued nor lost state.
- rst mid-transaction: next edge forces the reset values and returns to IDLE. The frame is abandoned with no rsp_valid, and sc drops immediately.
- Back-to-back requests: req_ready returns the cycle after rsp_valid. A request held valid in that cycle is accepted then.
- miso is used only in SHIFT sample cycles. X or Z on miso at other times must not propagate.

Decomposition:
- Package spi_rram_pkg holds:
  - the FSM state enum;
  - frame-length localparam NB;
  - R/W bit position constants;
  - the APB_RST address 5'h1F and signature 'h52414D, for benches.
- One sub-module, spi_half_tick: a parameterised CLK_DIV down-counter with a synchronous restart input and a tick output.

Test Plan:
- Read from the real spi_slave_rram after reset: addr 5'h1F, CLK_DIV=2 -> rsp_valid 671 cycles after acceptance; rsp_rdata = 160'h52414D; sc low in the cycle before rsp_valid.
- Write then read: addr 0, wdata = 160'h0123...CDEF (any 160-bit pattern) -> a subsequent read of addr 0 returns identical data; the write's rsp_rdata = 0.
- Frame check with a bit-level SPI monitor: write addr 5'h05, wdata 1 -> monitor sees 166 falling edges; first bits sampled 1,0,0,1,0,1; last bit 1; sclk low whenever sc transitions.
- req_valid held high throughout a busy transaction -> exactly one transaction per rsp_valid; the second request is accepted the cycle after rsp_valid.
- Assert rst for 1 cycle at bit 40 of a read -> sc=0 and sclk=0 next cycle; no rsp_valid; a following read of 5'h1F still returns 'h52414D.
- CLK_DIV=1 -> sclk period is 2 clk cycles; the read of 5'h1F is correct at a latency of 336 cycles.
